free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 4, meaning rename slots per cycle.
REQ-002 SHALL have parameter COMMIT_WIDTH, default 4, meaning commit slots per cycle.
REQ-003 SHALL have parameter PREG_NUM, default 64, meaning number of physical registers.
REQ-004 SHALL have parameter AREG_NUM, default 32, meaning number of architectural registers; DEPTH = PREG_NUM-AREG_NUM.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port resetn, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port alloc_req, input, FETCH_WIDTH, meaning per-slot request (slot valid and dst != 0).
REQ-008 SHALL have port alloc_en, input, 1, meaning the rename stage advances this cycle.
REQ-009 SHALL have port alloc_ok, output, 1, meaning enough free entries for all set alloc_req bits.
REQ-010 SHALL have port alloc_id, output, FETCH_WIDTH x log2(PREG_NUM), meaning physical dst per slot, i.e. pdst to rename.
REQ-011 SHALL have port free_valid, input, COMMIT_WIDTH, meaning per-slot release of an old pdst at commit.
REQ-012 SHALL have port free_id, input, COMMIT_WIDTH x log2(PREG_NUM), meaning the released preg ids.
REQ-013 SHALL have port commit_alloc_cnt, input, log2(COMMIT_WIDTH+1), meaning committed instructions that own an allocation.
REQ-014 SHALL have port flush, input, 1, meaning pipeline redirect that discards all uncommitted allocations.
REQ-015 SHALL have port overflow, output, 1, meaning sticky error flag.

Function
REQ-016 SHALL store preg ids in a DEPTH-entry circular buffer with spec head, retire head (rhead) and tail pointers, each log2(DEPTH)+1 bits including a wrap bit.
REQ-017 SHALL compute count = tail - head, modulo 2^(log2(DEPTH)+1).
REQ-018 SHALL drive alloc_ok = (count >= popcount(alloc_req)) combinationally, using the count before this cycle's frees (no same-cycle bypass).
REQ-019 SHALL compact slot ids: slot i with alloc_req[i]=1 gets buf[head + popcount(alloc_req[i-1:0])]; slots with alloc_req[i]=0 drive 0.
REQ-020 SHALL advance head by popcount(alloc_req) on the edge when alloc_en & alloc_ok & !flush; otherwise head holds.
REQ-021 SHALL write each free_valid slot's free_id compacted at tail + popcount(free_valid below it), and advance tail by popcount(free_valid), regardless of flush.
REQ-022 SHALL make a freed id allocatable from the next cycle onward (one-cycle latency).
REQ-023 SHALL advance rhead by commit_alloc_cnt every cycle, regardless of flush.
REQ-024 SHALL set head to the updated rhead (same-cycle commit included) on flush; flush has priority over allocation.
REQ-025 SHALL yield count == DEPTH on the cycle after a flush, given matched free/commit counts.
REQ-026 SHALL handle pointer wrap-around modulo 2*DEPTH, with the index taken from the low bits.
REQ-027 SHALL set overflow when a push would make count exceed DEPTH or rhead would pass head, and hold it until reset; buffer contents are then undefined.

Reset
REQ-028 SHALL, on resetn low, asynchronously set buf[k] = AREG_NUM+k, head = rhead = 0, tail = DEPTH (count = DEPTH), and overflow = 0.
REQ-029 SHALL drive alloc_ok = 1 and alloc_id = 0 during reset when alloc_req = 0.
REQ-030 SHALL discard all in-flight allocations on a reset asserted mid-operation, with the next cycle after release behaving as post-reset.

Verification
REQ-031 SHALL be checked: reset, then alloc_req=1111 with alloc_en=1 -> alloc_id={35,34,33,32} for slots 3..0, alloc_ok=1, count 28 next cycle.
REQ-032 SHALL be checked: after reset, alloc_req=1010 with alloc_en=1 -> slot1=32, slot3=33, slots 0 and 2 = 0, count 30.
REQ-033 SHALL be checked: 8 cycles of 1111 -> count 0; then alloc_req=0001 gives alloc_ok=0 with head unchanged, and alloc_req=0000 gives alloc_ok=1.
REQ-034 SHALL be checked: when empty, free_valid=0101 with ids 5,7 gives alloc_ok=0 for req 0001 in the same cycle; the next cycle req 0011 gives slot0=5, slot1=7.
REQ-035 SHALL be checked: allocate 32..39, then commit_alloc_cnt=2 with free ids 1,2 and flush in the same cycle -> count 32; next alloc of 1111 gives 34,35,36,37.
REQ-036 SHALL be checked: 3 full wrap-arounds of alloc/free with random masks -> no id duplicated, and overflow stays 0.

Source files
------------

// File: rtl/free_list_if.sv
// Rename/commit side bundle of the physical-register free list.
interface free_list_if #(
    parameter int FETCH_WIDTH  = 4,
    parameter int COMMIT_WIDTH = 4,
    parameter int PREG_NUM     = 64
);
    localparam int IW = $clog2(PREG_NUM);
    localparam int CW = $clog2(COMMIT_WIDTH + 1);

    logic [FETCH_WIDTH-1:0]           alloc_req;
    logic                             alloc_en;
    logic                             alloc_ok;
    logic [FETCH_WIDTH-1:0][IW-1:0]   alloc_id;
    logic [COMMIT_WIDTH-1:0]          free_valid;
    logic [COMMIT_WIDTH-1:0][IW-1:0]  free_id;
    logic [CW-1:0]                    commit_alloc_cnt;
    logic                             flush;
    logic                             overflow;

    modport master (
        output alloc_req, alloc_en, free_valid, free_id, commit_alloc_cnt, flush,
        input  alloc_ok, alloc_id, overflow
    );
    modport slave (
        input  alloc_req, alloc_en, free_valid, free_id, commit_alloc_cnt, flush,
        output alloc_ok, alloc_id, overflow
    );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register ids with speculative head, retire head
// and tail; flush rewinds the speculative head to the retire head.
module free_list #(
    parameter int FETCH_WIDTH  = 4,
    parameter int COMMIT_WIDTH = 4,
    parameter int PREG_NUM     = 64,
    parameter int AREG_NUM     = 32
) (
    input  logic       clk,
    input  logic       resetn,
    free_list_if.slave fl
);
    localparam int DEPTH = PREG_NUM - AREG_NUM;
    localparam int IDXW  = $clog2(DEPTH);
    localparam int PW    = IDXW + 1;
    localparam int IW    = $clog2(PREG_NUM);
    localparam int AW    = $clog2(FETCH_WIDTH + 1);
    localparam int FW    = $clog2(COMMIT_WIDTH + 1);

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] head, rhead, tail, count;
    logic [PW-1:0] head_nxt, rhead_nxt, tail_nxt, cnt_nxt, inflight;
    logic          ovf_q, ovf_set;

    logic [FETCH_WIDTH-1:0][AW-1:0]  a_pre;
    logic [AW-1:0]                   a_tot;
    logic [COMMIT_WIDTH-1:0][FW-1:0] f_pre;
    logic [FW-1:0]                   f_tot;

    // Exclusive prefix popcounts give each set slot its compacted offset.
    always_comb begin
        a_tot = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            a_pre[i] = a_tot;
            a_tot    = a_tot + AW'(fl.alloc_req[i]);
        end
        f_tot = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            f_pre[i] = f_tot;
            f_tot    = f_tot + FW'(fl.free_valid[i]);
        end
    end

    assign count       = tail - head;
    assign fl.alloc_ok = (count >= PW'(a_tot));
    assign fl.overflow = ovf_q;

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++)
            fl.alloc_id[i] = fl.alloc_req[i] ? mem[IDXW'(head + PW'(a_pre[i]))] : '0;
    end

    assign rhead_nxt = rhead + PW'(fl.commit_alloc_cnt);
    assign tail_nxt  = tail + PW'(f_tot);

    always_comb begin
        head_nxt = head;
        if (fl.flush)
            head_nxt = rhead_nxt;
        else if (fl.alloc_en && fl.alloc_ok)
            head_nxt = head + PW'(a_tot);
    end

    // Occupancy can legitimately reach DEPTH+COMMIT_WIDTH < 2*DEPTH only when
    // the bookkeeping is broken, so the modulo difference is exact here.
    assign cnt_nxt  = tail_nxt - head_nxt;
    assign inflight = head - rhead;
    assign ovf_set  = (cnt_nxt > PW'(DEPTH)) || (PW'(fl.commit_alloc_cnt) > inflight);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= IW'(AREG_NUM + k);
            head  <= '0;
            rhead <= '0;
            tail  <= PW'(DEPTH);
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < COMMIT_WIDTH; i++)
                if (fl.free_valid[i])
                    mem[IDXW'(tail + PW'(f_pre[i]))] <= fl.free_id[i];
            head  <= head_nxt;
            rhead <= rhead_nxt;
            tail  <= tail_nxt;
            if (ovf_set)
                ovf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_free_list.sv
// Directed vector table plus reset, overflow and random wrap-around sequences.
module tb_free_list;
    typedef logic [3:0][5:0] ids_t;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       en;
        logic [3:0] fv;
        ids_t       fid;
        logic [2:0] cac;
        logic       fl;
        logic       exp_ok;
        ids_t       exp_id;
        logic [5:0] exp_cnt;
    } vec_t;

    logic clk, resetn;
    int   checks = 0, failures = 0;
    vec_t tv[$];

    free_list_if #(.FETCH_WIDTH(4), .COMMIT_WIDTH(4), .PREG_NUM(64)) fl ();
    free_list #(.FETCH_WIDTH(4), .COMMIT_WIDTH(4), .PREG_NUM(64), .AREG_NUM(32)) dut (
        .clk(clk), .resetn(resetn), .fl(fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic ids_t ids(input int a3, input int a2, input int a1, input int a0);
        ids_t r;
        r[3] = 6'(a3); r[2] = 6'(a2); r[1] = 6'(a1); r[0] = 6'(a0);
        return r;
    endfunction

    function automatic vec_t mk(input bit rst, input logic [3:0] req, input logic en,
                                input logic [3:0] fv, input ids_t fid, input logic [2:0] cac,
                                input logic f, input logic ok, input ids_t eid, input int cnt);
        vec_t v;
        v.rst = rst; v.req = req; v.en = en; v.fv = fv; v.fid = fid; v.cac = cac;
        v.fl = f; v.exp_ok = ok; v.exp_id = eid; v.exp_cnt = 6'(cnt);
        return v;
    endfunction

    function automatic int pc(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    task automatic idle();
        fl.alloc_req = '0; fl.alloc_en = 1'b0; fl.free_valid = '0; fl.free_id = '0;
        fl.commit_alloc_cnt = '0; fl.flush = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle();
        resetn = 1'b0;
        #2 resetn = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        fl.alloc_req = v.req; fl.alloc_en = v.en; fl.free_valid = v.fv; fl.free_id = v.fid;
        fl.commit_alloc_cnt = v.cac; fl.flush = v.fl;
    endtask

    int   exp_q[$], infl[$];
    ids_t eid, fid;
    logic [3:0] req, fv;
    logic en, eok;
    int   n, p;

    initial begin
        resetn = 1'b1;
        idle();

        // Basic allocation and compaction
        tv.push_back(mk(1, 4'b1111, 1, 0, '0, 0, 0, 1, ids(35, 34, 33, 32), 28));
        tv.push_back(mk(1, 4'b1010, 1, 0, '0, 0, 0, 1, ids(33, 0, 32, 0), 30));
        // Drain to empty
        for (int k = 0; k < 8; k++)
            tv.push_back(mk(k == 0, 4'b1111, 1, 0, '0, 0, 0, 1,
                            ids(35 + 4*k, 34 + 4*k, 33 + 4*k, 32 + 4*k), 28 - 4*k));
        tv.push_back(mk(0, 4'b0001, 1, 0, '0, 0, 0, 0, ids(0, 0, 0, 32), 0));
        tv.push_back(mk(0, 4'b0000, 1, 0, '0, 0, 0, 1, ids(0, 0, 0, 0), 0));
        // Free while empty: no same-cycle bypass, usable next cycle
        tv.push_back(mk(0, 4'b0001, 1, 4'b0101, ids(0, 7, 0, 5), 0, 0, 0, ids(0, 0, 0, 32), 2));
        tv.push_back(mk(0, 4'b0011, 1, 0, '0, 0, 0, 1, ids(0, 0, 7, 5), 0));
        // Flush with same-cycle commit and frees
        tv.push_back(mk(1, 4'b1111, 1, 0, '0, 0, 0, 1, ids(35, 34, 33, 32), 28));
        tv.push_back(mk(0, 4'b1111, 1, 0, '0, 0, 0, 1, ids(39, 38, 37, 36), 24));
        tv.push_back(mk(0, 4'b0000, 0, 4'b0011, ids(0, 0, 2, 1), 2, 1, 1, ids(0, 0, 0, 0), 32));
        tv.push_back(mk(0, 4'b1111, 1, 0, '0, 0, 0, 1, ids(37, 36, 35, 34), 28));
        // Flush wins over a simultaneous allocation
        tv.push_back(mk(0, 4'b1111, 1, 0, '0, 0, 1, 1, ids(41, 40, 39, 38), 32));

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) begin
                do_reset();
                chk($sformatf("v%0d_reset_cnt", i), 64'(dut.count), 64'd32);
            end
            drive(tv[i]);
            #3;
            chk($sformatf("v%0d_alloc_ok", i), 64'(fl.alloc_ok), 64'(tv[i].exp_ok));
            chk($sformatf("v%0d_alloc_id", i), 64'(fl.alloc_id), 64'(tv[i].exp_id));
            @(posedge clk); #1;
            chk($sformatf("v%0d_count", i), 64'(dut.count), 64'(tv[i].exp_cnt));
            chk($sformatf("v%0d_overflow", i), 64'(fl.overflow), 64'd0);
            idle();
        end

        // Reset asserted mid-operation
        do_reset();
        fl.alloc_req = 4'b1111; fl.alloc_en = 1'b1;
        @(posedge clk); #1;
        chk("mid_pre_cnt", 64'(dut.count), 64'd28);
        idle();
        resetn = 1'b0;
        #1;
        chk("rst_alloc_ok", 64'(fl.alloc_ok), 64'd1);
        chk("rst_alloc_id", 64'(fl.alloc_id), 64'd0);
        chk("rst_cnt", 64'(dut.count), 64'd32);
        #1 resetn = 1'b1;
        fl.alloc_req = 4'b1111; fl.alloc_en = 1'b1;
        #2;
        chk("post_rst_id", 64'(fl.alloc_id), 64'(ids(35, 34, 33, 32)));
        @(posedge clk); #1;
        chk("post_rst_cnt", 64'(dut.count), 64'd28);

        // Overflow: push beyond DEPTH, then sticky until reset
        do_reset();
        fl.free_valid = 4'b0001; fl.free_id = ids(0, 0, 0, 3);
        @(posedge clk); #1;
        idle();
        chk("ovf_push", 64'(fl.overflow), 64'd1);
        @(posedge clk); #1;
        chk("ovf_sticky", 64'(fl.overflow), 64'd1);
        do_reset();
        #1 chk("ovf_cleared", 64'(fl.overflow), 64'd0);
        // Overflow: retire head passing spec head
        fl.commit_alloc_cnt = 3'd1;
        @(posedge clk); #1;
        idle();
        chk("ovf_rhead", 64'(fl.overflow), 64'd1);

        // Random alloc/free across several wrap-arounds against a queue model
        do_reset();
        exp_q.delete(); infl.delete();
        for (int k = 32; k < 64; k++) exp_q.push_back(k);
        for (int c = 0; c < 160; c++) begin
            req = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 3) != 0);
            fv  = 4'($urandom_range(0, 15));
            n   = pc(fv);
            if (n > infl.size()) begin fv = '0; n = 0; end
            fid = '0;
            for (int s = 0; s < 4; s++)
                if (fv[s]) fid[s] = 6'(infl.pop_front());
            fl.alloc_req = req; fl.alloc_en = en; fl.free_valid = fv; fl.free_id = fid;
            fl.commit_alloc_cnt = 3'(n); fl.flush = 1'b0;
            eok = (exp_q.size() >= pc(req));
            eid = '0;
            p = 0;
            for (int s = 0; s < 4; s++)
                if (req[s]) begin
                    if (p < exp_q.size()) eid[s] = 6'(exp_q[p]);
                    else eid[s] = fl.alloc_id[s];
                    p++;
                end
            #3;
            chk($sformatf("rnd%0d_ok", c), 64'(fl.alloc_ok), 64'(eok));
            if (eok) chk($sformatf("rnd%0d_id", c), 64'(fl.alloc_id), 64'(eid));
            if (en && eok)
                for (int s = 0; s < pc(req); s++) infl.push_back(exp_q.pop_front());
            @(posedge clk); #1;
            for (int s = 0; s < 4; s++)
                if (fv[s]) exp_q.push_back(int'(fid[s]));
            chk($sformatf("rnd%0d_cnt", c), 64'(dut.count), 64'(exp_q.size()));
            chk($sformatf("rnd%0d_ovf", c), 64'(fl.overflow), 64'd0);
        end
        // Every id must be present exactly once across free list and in-flight set
        begin
            int seen [64];
            int dup;
            dup = 0;
            foreach (seen[k]) seen[k] = 0;
            foreach (exp_q[k]) seen[exp_q[k]]++;
            foreach (infl[k]) seen[infl[k]]++;
            for (int k = 32; k < 64; k++) if (seen[k] != 1) dup++;
            chk("rnd_unique_ids", 64'(dup), 64'd0);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
